// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one instruction-memory read
// per cycle, buffers {instr, pc} pairs in a small prefetch FIFO and presents
// the head to decode over a valid/ready handshake. A taken-branch redirect
// flushes the FIFO and restarts fetch at the new (word-aligned) PC.
module fetch_unit #(
  parameter int              PC_W     = 64,
  parameter int              ADDR_W   = 5,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [PC_W-1:0]   if_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  pc_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic [31:0]     instr_arr [DEPTH];
  logic [PC_W-1:0] pc_arr    [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic [PC_W-1:0] redirect_aligned;

  // Handshake and fetch-enable decode. The head is hidden during reset so a
  // mid-operation reset never presents stale entries, and a redirect blocks
  // both the pop and the read so nothing from the wrong path is consumed.
  assign full             = (count_reg == CNT_W'(DEPTH));
  assign if_valid         = (count_reg != '0) && !reset;
  assign pop              = if_valid && if_ready && !redirect;
  assign push             = fetch_en && !redirect && !reset && (!full || pop);
  assign imem_rd_en       = push;
  assign imem_addr        = pc_reg[ADDR_W+1:2];
  assign redirect_aligned = redirect_pc & ~PC_W'(3);

  // Head is read combinationally; outputs are zeroed while empty so nothing
  // from an old entry leaks onto the decode bus.
  assign if_instr = if_valid ? instr_arr[head_reg] : '0;
  assign if_pc    = if_valid ? pc_arr[head_reg]    : '0;

  // Per-entry storage: each slot captures the memory word and its PC when
  // the tail points at it. Data is not reset; count gates its visibility.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0]     instr_q;
      logic [PC_W-1:0] pc_q;

      // Capture the fetched word and its PC on a push into this slot
      always_ff @(posedge clk) begin
        if (push && (tail_reg == PTR_W'(gi))) begin
          instr_q <= imem_instr;
          pc_q    <= pc_reg;
        end
      end

      assign instr_arr[gi] = instr_q;
      assign pc_arr[gi]    = pc_q;
    end
  endgenerate

  // PC, pointers and occupancy: reset beats redirect, redirect beats
  // push/pop. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (redirect) begin
      pc_reg    <= redirect_aligned;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        pc_reg   <= pc_reg + PC_W'(4);
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of the prefetch
// buffer and PC is stepped alongside the DUT, every cycle's outputs are
// compared against it, and directed scenarios pin key values with literals.
module tb_fetch_unit;

  localparam int PC_W   = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_en;
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [PC_W-1:0]   if_pc;

  logic [31:0] mem [32];

  ent_t        q[$];
  logic [63:0] mpc;

  int n_cmp = 0;
  int n_bad = 0;

  // Values sampled during the most recent step, for directed literal checks
  logic        s_rd;
  logic [4:0]  s_addr;
  logic        s_valid;
  logic [31:0] s_instr;
  logic [63:0] s_pc;

  fetch_unit #(
    .PC_W    (PC_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .RESET_PC('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .imem_rd_en (imem_rd_en),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_valid   (if_valid),
    .if_ready   (if_ready),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory
  assign imem_instr = mem[imem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs at negedge against the
  // model, then advance the model at the rising edge.
  task automatic step(input logic fe, input logic rdy, input logic red,
                      input logic [63:0] rpc, input logic rst);
    logic exp_valid, exp_pop, exp_push;
    ent_t hd;
    fetch_en    = fe;
    if_ready    = rdy;
    redirect    = red;
    redirect_pc = rpc;
    reset       = rst;
    @(negedge clk);
    exp_valid = !rst && (q.size() > 0);
    hd        = exp_valid ? q[0] : '0;
    exp_pop   = exp_valid && rdy && !red;
    exp_push  = fe && !red && !rst && ((q.size() < DEPTH) || exp_pop);
    chk("imem_rd_en", 64'(imem_rd_en), 64'(exp_push));
    chk("imem_addr",  64'(imem_addr),  64'(mpc[6:2]));
    chk("if_valid",   64'(if_valid),   64'(exp_valid));
    chk("if_instr",   64'(if_instr),   64'(hd.instr));
    chk("if_pc",      if_pc,           hd.pc);
    s_rd    = imem_rd_en;
    s_addr  = imem_addr;
    s_valid = if_valid;
    s_instr = if_instr;
    s_pc    = if_pc;
    if (exp_pop) $display("pop  pc=%h instr=%h", hd.pc, hd.instr);
    @(posedge clk);
    if (rst) begin
      q.delete();
      mpc = 64'h0;
    end else if (red) begin
      q.delete();
      mpc = {rpc[63:2], 2'b00};
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_push) begin
        q.push_back('{instr: mem[mpc[6:2]], pc: mpc});
        mpc = mpc + 64'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h8b1f03e5;
    prog[1] = 32'hf84000a4;
    prog[2] = 32'h8b040086;
    prog[3] = 32'hf80010a6;
    for (int i = 0; i < 32; i++) mem[i] = (i < 4) ? prog[i] : $urandom;

    fetch_en = 0; if_ready = 0; redirect = 0; redirect_pc = '0; reset = 1;
    mpc = 64'h0;
    repeat (2) @(posedge clk);
    #1;

    // 1: straight-line fetch with decode always ready
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      if (k < 4) chk("t1_addr", 64'(s_addr), 64'(k));
      if (k >= 1) begin
        chk("t1_pc",    s_pc,          64'(4 * (k - 1)));
        chk("t1_instr", 64'(s_instr),  64'(prog[k-1]));
      end
    end

    // 2: decode stalled from reset, FIFO fills, then drains in order
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      chk("t2_rd", 64'(s_rd), (k < 4) ? 64'd1 : 64'd0);
    end
    chk("t2_model_pc", mpc, 64'h10);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("t2_instr", 64'(s_instr), 64'(prog[k]));
      if (k == 0) begin
        chk("t2_resume_rd",   64'(s_rd),   64'd1);
        chk("t2_resume_addr", 64'(s_addr), 64'd4);
      end
    end

    // 3: redirect with two entries queued, misaligned target
    do_reset();
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 64'h43, 1'b0);
    chk("t3_redir_rd", 64'(s_rd), 64'd0);
    chk("t3_model_pc", mpc, 64'h40);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("t3_valid", 64'(s_valid), 64'd0);
    chk("t3_addr",  64'(s_addr),  64'd16);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("t3_pc", s_pc, 64'h40);

    // 4: full FIFO streaming with no bubbles
    do_reset();
    repeat (5) step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t4_full_rd", 64'(s_rd), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("t4_rd",    64'(s_rd),    64'd1);
      chk("t4_valid", 64'(s_valid), 64'd1);
      chk("t4_pc",    s_pc,         64'(4 * k));
    end
    chk("t4_model_cnt", 64'(q.size()), 64'd4);

    // 5: redirect while head would be accepted, then drain with fetch off
    step(1'b1, 1'b1, 1'b1, 64'h20, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t5_valid", 64'(s_valid), 64'd0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("t5_rd", 64'(s_rd), 64'd0);
      chk("t5_addr", 64'(s_addr), 64'd11);
    end
    chk("t5_empty", 64'(s_valid), 64'd0);

    // 6: reset with 3 entries queued at pc 0x1C, then PC wraparound
    step(1'b1, 1'b0, 1'b1, 64'h10, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t6_model_pc", mpc, 64'h1C);
    step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
    chk("t6_rst_valid", 64'(s_valid), 64'd0);
    chk("t6_rst_rd",    64'(s_rd),    64'd0);
    step(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("t6_after_valid", 64'(s_valid), 64'd0);
    chk("t6_after_addr",  64'(s_addr),  64'd0);
    step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t6_top_addr", 64'(s_addr), 64'd31);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t6_wrap_addr", 64'(s_addr), 64'd0);
    chk("t6_top_pc",    s_pc,        64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic fe, rdy, red, rst;
      logic [63:0] rpc;
      fe  = ($urandom_range(99) < 80);
      rdy = ($urandom_range(99) < 60);
      red = ($urandom_range(99) < 5);
      rst = ($urandom_range(199) < 2);
      rpc = ($urandom_range(3) == 0) ? {32'hFFFF_FFFF, $urandom} : 64'($urandom_range(255));
      step(fe, rdy, red, rpc, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
